speicher_controller: RTL and testbench
======================================

Name: speicher_controller

Overview:
- Memory-side responder for the processor control FSM's memory handshakes.
- Accepts level-held requests for instruction fetch (LoadBefehlSignal), data load (LoadDatenSignal) and data store (StoreDatenSignal).
- Runs one transaction at a time on a simple request/acknowledge memory bus.
- Answers with one-cycle completion pulses BefehlGeladen, DatenGeladen and DatenGespeichert.
- Sits between the processor core and the RAM/bus fabric.

Parameters:
- ADDR_WIDTH, 32, width of all addresses.
- DATA_WIDTH, 32, width of words; fixed at 32, word accesses only.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for MemAck before the access is aborted; 0 disables the timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- LoadBefehlSignal  in  1  instruction fetch request, held high until BefehlGeladen.
- LoadDatenSignal  in  1  data load request, held high until DatenGeladen.
- StoreDatenSignal  in  1  data store request, held high until DatenGespeichert.
- BefehlAdresse  in  ADDR_WIDTH  fetch address (PC).
- DatenAdresse  in  ADDR_WIDTH  load/store address.
- StoreDaten  in  DATA_WIDTH  store data.
- BefehlGeladen  out  1  one-cycle pulse: fetch complete.
- Befehl  out  DATA_WIDTH  fetched instruction, held until next fetch completes.
- DatenGeladen  out  1  one-cycle pulse: load complete.
- Daten  out  DATA_WIDTH  loaded word, held until next load completes.
- DatenGespeichert  out  1  one-cycle pulse: store complete.
- Fehler  out  1  sticky error flag (misaligned address or timeout); cleared only by Reset.
- MemRequest  out  1  bus request, high from issue until MemAck is sampled.
- MemWrite  out  1  1 = write, 0 = read; valid while MemRequest is high.
- MemAdresse  out  ADDR_WIDTH  bus address, stable while MemRequest is high.
- MemSchreibDaten  out  DATA_WIDTH  bus write data, stable while MemRequest is high.
- MemAck  in  1  bus completion; read data is valid in the same cycle.
- MemLeseDaten  in  DATA_WIDTH  bus read data.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, including Befehl, Daten, MemAdresse and MemSchreibDaten. State returns to IDLE.
- States: IDLE, BUS, DONE.
- IDLE: a request is sampled high at edge k.
  - Priority: Store > Load > Fetch.
  - Latch the request kind, the address, and (for a store) StoreDaten.
  - Address aligned (addr[1:0] == 0) → go to BUS. MemRequest=1 from cycle k+1, timeout counter cleared.
  - Address misaligned → go to DONE with no bus access. Fehler set to 1. For a load or fetch, the data register is loaded with 0.
- BUS: hold MemRequest, MemWrite, MemAdresse and MemSchreibDaten constant.
  - MemAck sampled high → MemRequest drops at the same edge. Reads capture MemLeseDaten into Befehl or Daten. Go to DONE.
  - If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES with no ack → drop MemRequest, set Fehler, load 0 into the data register (reads), go to DONE.
  - A MemAck arriving after an abort is ignored.
- DONE, exactly one cycle: assert the pulse that matches the latched kind, then go to IDLE.
  - Request inputs are ignored in DONE, because the core drops its request on the edge it sees the pulse.
  - A request held high after DONE starts a new transaction, which is legal.
- Minimum latency: request in cycle 0, MemRequest in cycle 1, MemAck in cycle 1 → pulse in cycle 2. In general the pulse comes one cycle after MemAck is sampled.
- Requests that drop while in BUS do not cancel the transaction; it runs to completion.
- MemAck while in IDLE or DONE is ignored.
- Reset mid-transaction: MemRequest=0 on the next cycle, no completion pulse, the bus transaction is abandoned. The backend must tolerate a request being withdrawn.
- The timeout counter saturates and is sized as clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Test Plan:
- Fetch: BefehlAdresse=0x100, MemAck in cycle 3 with MemLeseDaten=0xDEADBEEF → MemRequest=1/MemWrite=0/MemAdresse=0x100 in cycles 1–3; BefehlGeladen=1 only in cycle 4; Befehl=0xDEADBEEF and held afterwards.
- Store: DatenAdresse=0x2004, StoreDaten=0x12345678, immediate MemAck → MemWrite=1 with that address and data in cycle 1; DatenGespeichert pulses in cycle 2; Daten unchanged.
- Simultaneous StoreDatenSignal=1 and LoadBefehlSignal=1 → store is issued first; the fetch, still held, is issued in the cycle after DatenGespeichert.
- Misaligned load, DatenAdresse=0x2002 → MemRequest never rises; DatenGeladen pulses in cycle 1; Daten=0; Fehler=1 stays high until Reset.
- TIMEOUT_CYCLES=4, MemAck never asserted → MemRequest high for 4 cycles then low; DatenGeladen pulse; Fehler=1; a later MemAck is ignored.
- Reset asserted in cycle 2 of BUS → MemRequest=0 next cycle; no completion pulse; all outputs 0; a new fetch afterwards completes normally.

Source files
------------

// File: rtl/speicher_controller.sv
// Memory-side responder for the core's fetch/load/store handshakes.
// One transaction at a time on a request/acknowledge bus; completion is
// reported with a one-cycle pulse per request kind. All outputs registered.
module speicher_controller #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  LoadBefehlSignal,
  input  logic                  LoadDatenSignal,
  input  logic                  StoreDatenSignal,
  input  logic [ADDR_WIDTH-1:0] BefehlAdresse,
  input  logic [ADDR_WIDTH-1:0] DatenAdresse,
  input  logic [DATA_WIDTH-1:0] StoreDaten,
  output logic                  BefehlGeladen,
  output logic [DATA_WIDTH-1:0] Befehl,
  output logic                  DatenGeladen,
  output logic [DATA_WIDTH-1:0] Daten,
  output logic                  DatenGespeichert,
  output logic                  Fehler,
  output logic                  MemRequest,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAdresse,
  output logic [DATA_WIDTH-1:0] MemSchreibDaten,
  input  logic                  MemAck,
  input  logic [DATA_WIDTH-1:0] MemLeseDaten
);

  localparam int unsigned CntWidth =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value at which the next unacknowledged cycle reaches the limit.
  localparam logic [CntWidth-1:0] CntLast =
      (TIMEOUT_CYCLES > 0) ? CntWidth'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;
  typedef enum logic [1:0] {KindFetch, KindLoad, KindStore} kind_e;

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] befehl_q, befehl_d;
  logic [DATA_WIDTH-1:0] daten_q, daten_d;
  logic                  fehler_q, fehler_d;
  logic                  befehl_geladen_q, befehl_geladen_d;
  logic                  daten_geladen_q, daten_geladen_d;
  logic                  daten_gesp_q, daten_gesp_d;

  logic                  finish;
  logic [DATA_WIDTH-1:0] load_val;
  logic [ADDR_WIDTH-1:0] req_addr;

  // Next-state: request arbitration, bus wait with timeout, completion pulse.
  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    cnt_d            = cnt_q;
    mem_req_d        = mem_req_q;
    mem_write_d      = mem_write_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    befehl_d         = befehl_q;
    daten_d          = daten_q;
    fehler_d         = fehler_q;
    befehl_geladen_d = 1'b0;
    daten_geladen_d  = 1'b0;
    daten_gesp_d     = 1'b0;
    finish           = 1'b0;
    load_val         = '0;
    req_addr         = DatenAdresse;

    unique case (state_q)
      StIdle: begin
        if (StoreDatenSignal || LoadDatenSignal || LoadBefehlSignal) begin
          if (StoreDatenSignal) begin
            kind_d      = KindStore;
            mem_wdata_d = StoreDaten;
          end else if (LoadDatenSignal) begin
            kind_d = KindLoad;
          end else begin
            kind_d   = KindFetch;
            req_addr = BefehlAdresse;
          end
          mem_addr_d  = req_addr;
          mem_write_d = StoreDatenSignal;
          if (req_addr[1:0] == 2'b00) begin
            state_d   = StBus;
            mem_req_d = 1'b1;
            cnt_d     = '0;
          end else begin
            // Misaligned: complete immediately with error and zero data.
            fehler_d = 1'b1;
            finish   = 1'b1;
          end
        end
      end
      StBus: begin
        if (MemAck) begin
          mem_req_d = 1'b0;
          load_val  = MemLeseDaten;
          finish    = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          mem_req_d = 1'b0;
          fehler_d  = 1'b1;
          finish    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Completion: the pulse for the DONE cycle and the read-data update.
    if (finish) begin
      state_d = StDone;
      unique case (kind_d)
        KindFetch: begin
          befehl_d         = load_val;
          befehl_geladen_d = 1'b1;
        end
        KindLoad: begin
          daten_d         = load_val;
          daten_geladen_d = 1'b1;
        end
        KindStore: begin
          daten_gesp_d = 1'b1;
        end
        default: begin
          befehl_geladen_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q          <= StIdle;
      kind_q           <= KindFetch;
      cnt_q            <= '0;
      mem_req_q        <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      befehl_q         <= '0;
      daten_q          <= '0;
      fehler_q         <= 1'b0;
      befehl_geladen_q <= 1'b0;
      daten_geladen_q  <= 1'b0;
      daten_gesp_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      cnt_q            <= cnt_d;
      mem_req_q        <= mem_req_d;
      mem_write_q      <= mem_write_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      befehl_q         <= befehl_d;
      daten_q          <= daten_d;
      fehler_q         <= fehler_d;
      befehl_geladen_q <= befehl_geladen_d;
      daten_geladen_q  <= daten_geladen_d;
      daten_gesp_q     <= daten_gesp_d;
    end
  end

  assign BefehlGeladen    = befehl_geladen_q;
  assign Befehl           = befehl_q;
  assign DatenGeladen     = daten_geladen_q;
  assign Daten            = daten_q;
  assign DatenGespeichert = daten_gesp_q;
  assign Fehler           = fehler_q;
  assign MemRequest       = mem_req_q;
  assign MemWrite         = mem_write_q;
  assign MemAdresse       = mem_addr_q;
  assign MemSchreibDaten  = mem_wdata_q;

endmodule

// File: tb/tb_speicher_controller.sv
// Bench for speicher_controller: directed scenarios followed by randomized
// transactions, checked against a transaction-level timing/data model.
module tb_speicher_controller;

  localparam int unsigned Tmo = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        LoadBefehlSignal, LoadDatenSignal, StoreDatenSignal;
  logic [31:0] BefehlAdresse, DatenAdresse, StoreDaten;
  logic        BefehlGeladen, DatenGeladen, DatenGespeichert, Fehler;
  logic [31:0] Befehl, Daten;
  logic        MemRequest, MemWrite, MemAck;
  logic [31:0] MemAdresse, MemSchreibDaten, MemLeseDaten;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: last fetched / loaded word and the sticky error flag.
  logic [31:0] m_befehl = '0;
  logic [31:0] m_daten  = '0;
  bit          m_fehler = 1'b0;

  speicher_controller #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(Tmo)
  ) u_dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .LoadBefehlSignal(LoadBefehlSignal),
    .LoadDatenSignal (LoadDatenSignal),
    .StoreDatenSignal(StoreDatenSignal),
    .BefehlAdresse   (BefehlAdresse),
    .DatenAdresse    (DatenAdresse),
    .StoreDaten      (StoreDaten),
    .BefehlGeladen   (BefehlGeladen),
    .Befehl          (Befehl),
    .DatenGeladen    (DatenGeladen),
    .Daten           (Daten),
    .DatenGespeichert(DatenGespeichert),
    .Fehler          (Fehler),
    .MemRequest      (MemRequest),
    .MemWrite        (MemWrite),
    .MemAdresse      (MemAdresse),
    .MemSchreibDaten (MemSchreibDaten),
    .MemAck          (MemAck),
    .MemLeseDaten    (MemLeseDaten)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input bit req, input bit pb, input bit pd, input bit ps);
    check_eq("mem_request", 32'(MemRequest), 32'(req));
    check_eq("befehl_geladen", 32'(BefehlGeladen), 32'(pb));
    check_eq("daten_geladen", 32'(DatenGeladen), 32'(pd));
    check_eq("daten_gespeichert", 32'(DatenGespeichert), 32'(ps));
    check_eq("fehler", 32'(Fehler), 32'(m_fehler));
    check_eq("befehl", Befehl, m_befehl);
    check_eq("daten", Daten, m_daten);
  endtask

  // One transaction. kind: 0 fetch, 1 load, 2 store. Cycle 0 is the cycle the
  // request is first presented in IDLE; ack_cyc is the cycle MemAck is driven.
  // Returns after the completion (DONE) cycle has been checked.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_cyc, input logic [31:0] rdata,
                         input bit extra_fetch, input logic [31:0] faddr,
                         input bit drop_early);
    bit mis  = (addr[1:0] != 2'b00);
    bit tmo  = !mis && (ack_cyc > int'(Tmo));
    int last = mis ? 0 : (tmo ? int'(Tmo) : ack_cyc);
    bit extra_load = (kind == 2) && ($urandom_range(1, 0) == 1);
    bit done;
    bit exp_req;
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge Clock);
      #1;
      if (c == 0) begin
        LoadBefehlSignal = (kind == 0) || extra_fetch;
        LoadDatenSignal  = (kind == 1) || extra_load;
        StoreDatenSignal = (kind == 2);
        BefehlAdresse    = (kind == 0) ? addr : (extra_fetch ? faddr : $urandom());
        DatenAdresse     = (kind != 0) ? addr : $urandom();
        StoreDaten       = (kind == 2) ? wdata : $urandom();
        MemAck           = 1'($urandom_range(1, 0));
      end else begin
        if (drop_early && c >= 2) begin
          LoadBefehlSignal = 1'b0;
          LoadDatenSignal  = 1'b0;
          StoreDatenSignal = 1'b0;
        end
        // Address/data inputs may wander once the request is latched.
        DatenAdresse = $urandom();
        StoreDaten   = $urandom();
        if (!extra_fetch) BefehlAdresse = $urandom();
        MemAck = (c == ack_cyc);
      end
      MemLeseDaten = (c == ack_cyc) ? rdata : $urandom();
      @(negedge Clock);
      done    = (c == last + 1);
      exp_req = !mis && (c >= 1) && (c <= last);
      if (done) begin
        if (mis || tmo) m_fehler = 1'b1;
        if (kind == 0) m_befehl = (mis || tmo) ? 32'h0 : rdata;
        if (kind == 1) m_daten  = (mis || tmo) ? 32'h0 : rdata;
      end
      check_state(exp_req, done && kind == 0, done && kind == 1, done && kind == 2);
      if (exp_req) begin
        check_eq("mem_write", 32'(MemWrite), 32'(kind == 2));
        check_eq("mem_adresse", MemAdresse, addr);
        if (kind == 2) check_eq("mem_schreibdaten", MemSchreibDaten, wdata);
      end
    end
  endtask

  // Quiet cycles with no requests; MemAck toggles and must be ignored.
  task automatic idle(input int n, input bit stray_ack);
    for (int c = 0; c < n; c++) begin
      @(posedge Clock);
      #1;
      LoadBefehlSignal = 1'b0;
      LoadDatenSignal  = 1'b0;
      StoreDatenSignal = 1'b0;
      MemAck           = stray_ack ? 1'b1 : 1'($urandom_range(1, 0));
      MemLeseDaten     = $urandom();
      @(negedge Clock);
      check_state(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Fetch that never gets an ack; Reset hits in its second bus cycle.
  task automatic reset_mid();
    for (int c = 0; c <= 4; c++) begin
      @(posedge Clock);
      #1;
      MemAck = 1'b0;
      if (c == 0) begin
        LoadBefehlSignal = 1'b1;
        LoadDatenSignal  = 1'b0;
        StoreDatenSignal = 1'b0;
        BefehlAdresse    = 32'h0000_0400;
      end
      if (c == 2) Reset = 1'b1;
      if (c == 3) begin
        Reset            = 1'b0;
        LoadBefehlSignal = 1'b0;
      end
      @(negedge Clock);
      if (c == 3) begin
        m_befehl = '0;
        m_daten  = '0;
        m_fehler = 1'b0;
      end
      check_state((c == 1) || (c == 2), 1'b0, 1'b0, 1'b0);
      if (c == 3) begin
        check_eq("rst_mem_write", 32'(MemWrite), 32'h0);
        check_eq("rst_mem_adresse", MemAdresse, 32'h0);
        check_eq("rst_mem_schreibdaten", MemSchreibDaten, 32'h0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, fa;
    int          kind, ack;
    bit          xf, pend_fetch;

    Reset            = 1'b1;
    LoadBefehlSignal = 1'b0;
    LoadDatenSignal  = 1'b0;
    StoreDatenSignal = 1'b0;
    BefehlAdresse    = '0;
    DatenAdresse     = '0;
    StoreDaten       = '0;
    MemAck           = 1'b0;
    MemLeseDaten     = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_state(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("init_mem_write", 32'(MemWrite), 32'h0);
    check_eq("init_mem_adresse", MemAdresse, 32'h0);
    check_eq("init_mem_schreibdaten", MemSchreibDaten, 32'h0);
    Reset = 1'b0;

    // Directed scenarios.
    run_txn(0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    idle(2, 1'b0);
    run_txn(2, 32'h0000_2004, 32'h1234_5678, 1, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0);
    run_txn(2, 32'h0000_3000, 32'hCAFE_F00D, 2, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
    run_txn(0, 32'h0000_0200, 32'h0, 1, 32'h0BAD_C0DE, 1'b0, 32'h0, 1'b0);
    run_txn(1, 32'h0000_4000, 32'h0, 2, 32'h7777_1111, 1'b0, 32'h0, 1'b1);
    idle(1, 1'b0);
    run_txn(1, 32'h0000_2002, 32'h0, 1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    idle(3, 1'b0);
    reset_mid();
    run_txn(0, 32'h0000_0104, 32'h0, 1, 32'h1357_9BDF, 1'b0, 32'h0, 1'b0);
    run_txn(1, 32'h0000_5000, 32'h0, Tmo + 2, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(3, 1'b1);
    reset_mid();
    run_txn(0, 32'h0000_0108, 32'h0, 2, 32'h2468_ACE0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic.
    pend_fetch = 1'b0;
    fa         = '0;
    for (int i = 0; i < 120; i++) begin
      ack = ($urandom_range(7, 0) == 0) ? int'($urandom_range(Tmo + 2, Tmo + 1))
                                        : int'($urandom_range(Tmo, 1));
      if (pend_fetch) begin
        pend_fetch = 1'b0;
        run_txn(0, fa, $urandom(), ack, $urandom(), 1'b0, 32'h0, 1'b0);
      end else begin
        if (i % 24 == 23) reset_mid();
        kind = int'($urandom_range(2, 0));
        a    = $urandom();
        a[1:0] = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        xf   = (kind != 0) && ($urandom_range(3, 0) == 0);
        fa   = $urandom();
        fa[1:0] = 2'b00;
        run_txn(kind, a, $urandom(), ack, $urandom(), xf, fa,
                $urandom_range(3, 0) == 0);
        pend_fetch = xf;
        if (!xf) idle(int'($urandom_range(2, 0)), 1'b0);
      end
    end
    idle(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
